// File: rtl/vga_timing_gen_if.sv
// VGA raster output bundle: syncs, display enable, pixel coordinate and frame tick.
// Master drives the bundle; renderers and the output register take the slave view.
interface vga_timing_gen_if;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] x;
    logic [8:0] y;
    logic       frame_tick;

    modport master (
        output hsync,
        output vsync,
        output display_on,
        output x,
        output y,
        output frame_tick
    );

    modport slave (
        input hsync,
        input vsync,
        input display_on,
        input x,
        input y,
        input frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default); VGA_CLK_DIV2_EN halves the pixel rate.
// Latency: position held in the counters appears on the registered outputs one pixel strobe later.
// Backpressure: none, free-running; downstream must sample every pixel period.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       frame_tick_q, frame_tick_d;
    logic       pix_stb;
    logic       in_active;

`ifdef VGA_CLK_DIV2_EN
    logic toggle_q, toggle_d;

    always_comb begin
        toggle_d = ~toggle_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign pix_stb = toggle_q;
`else
    assign pix_stb = 1'b1;
`endif

    assign in_active = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);

    always_comb begin
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        display_on_d = display_on_q;
        x_d          = x_q;
        y_d          = y_q;
        // The tick is a single clk even when the pixel period spans two clks.
        frame_tick_d = 1'b0;
        if (pix_stb) begin
            display_on_d = in_active;
            hsync_d      = !((hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C));
            vsync_d      = !((vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C));
            x_d          = in_active ? hcnt_q : 10'd0;
            y_d          = in_active ? vcnt_q[8:0] : 9'd0;
            frame_tick_d = (hcnt_q == 10'd0) && (vcnt_q == V_ACT_C);
            if (hcnt_q == H_LAST_C) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == V_LAST_C) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q       <= 10'd0;
            vcnt_q       <= 10'd0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            display_on_q <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 9'd0;
            frame_tick_q <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            display_on_q <= display_on_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.display_on = display_on_q;
    assign vga.x          = x_q;
    assign vga.y          = y_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-timing instance so whole frames fit
// in a short run; expected outputs come from a position-index model pushed into a scoreboard queue.
module tb_vga_timing_gen;

`ifdef VGA_CLK_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Shrunken timing for the second instance: 32 x 19 = 608 pixel periods per frame.
    localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [8:0] y;
        logic       ft;
    } vout_t;

    typedef struct packed {
        vout_t a;
        vout_t b;
    } exp_t;

    localparam vout_t RST_OUT = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 10'd0, y: 9'd0, ft: 1'b0};

    logic clk;
    logic rst_n;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   since_rst = 0;
    int   ft_exp_cnt = 0;
    int   ft_got_cnt = 0;
    bit   meas_en = 1'b0;
    int   de_cnt = 0;
    int   hs_low_cnt = 0;
    bit   stim_done = 1'b0;

    // Output for linear pixel index p since reset, straight from the raster rules.
    function automatic vout_t pos_out(input int p, input int ha, input int hf, input int hs,
                                      input int hb, input int va, input int vf, input int vs,
                                      input int vb);
        vout_t r;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int h  = p % ht;
        int v  = (p / ht) % vt;
        r.de = (h < ha) && (v < va);
        r.hs = !((h >= ha + hf) && (h < ha + hf + hs));
        r.vs = !((v >= va + vf) && (v < va + vf + vs));
        r.x  = r.de ? 10'(h) : 10'd0;
        r.y  = r.de ? 9'(v) : 9'd0;
        r.ft = (h == 0) && (v == va);
        return r;
    endfunction

    // Clocks since reset release -> pixel periods presented so far.
    function automatic vout_t expect_out(input int k, input int ha, input int hf, input int hs,
                                         input int hb, input int va, input int vf, input int vs,
                                         input int vb);
        vout_t r;
        int n = k / DIV;
        if (n == 0) return RST_OUT;
        r = pos_out(n - 1, ha, hf, hs, hb, va, vf, vs, vb);
        if ((k % DIV) != 0) r.ft = 1'b0;
        return r;
    endfunction

    task automatic step(input logic r);
        exp_t e;
        rst_n = r;
        @(posedge clk);
        #1;
        if (!r) since_rst = 0;
        else    since_rst = since_rst + 1;
        e.a = expect_out(since_rst, 640, 16, 96, 48, 480, 10, 2, 33);
        e.b = expect_out(since_rst, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
        if (e.b.ft) ft_exp_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic cmp(input string nm, input vout_t got, input vout_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ft=%b expected hs=%b vs=%b de=%b x=%0d y=%0d ft=%b",
                     nm, $time, got.hs, got.vs, got.de, got.x, got.y, got.ft,
                     exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ft);
        end
    endtask

    task automatic cmp_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: pops one expectation per clk and compares it to what both DUTs present.
    initial begin
        exp_t  e;
        vout_t ga, gb;
        forever begin
            @(negedge clk);
            ga = '{hs: if_a.hsync, vs: if_a.vsync, de: if_a.display_on,
                   x: if_a.x, y: if_a.y, ft: if_a.frame_tick};
            gb = '{hs: if_b.hsync, vs: if_b.vsync, de: if_b.display_on,
                   x: if_b.x, y: if_b.y, ft: if_b.frame_tick};
            if (gb.ft === 1'b1) ft_got_cnt++;
            if (meas_en) begin
                if (ga.de === 1'b1) de_cnt++;
                if (ga.hs === 1'b0) hs_low_cnt++;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("dut_a", ga, e.a);
                cmp("dut_b", gb, e.b);
            end
        end
    end

    initial begin
        int seg_len;
        int rst_len;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0);

        // First three full-size lines, with whole-line duty counts on the side.
        meas_en = 1'b1;
        run(3 * 800 * DIV);
        meas_en = 1'b0;

        // Fresh start, then a one-clk reset at line 6, x=5 of the small raster.
        step(1'b0);
        run((6 * 32 + 5 + 1) * DIV);
        step(1'b0);
        run(2 * 608 * DIV + 50);

        for (int s = 0; s < 4; s++) begin
            rst_len = $urandom_range(1, 3);
            seg_len = $urandom_range(100, 1500) * DIV;
            for (int i = 0; i < rst_len; i++) step(1'b0);
            run(seg_len);
        end
        run(608 * DIV);

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
        cmp_int("scoreboard_drained", exp_q.size(), 0);
        cmp_int("line_display_on_clks", de_cnt, 3 * 640 * DIV);
        cmp_int("line_hsync_low_clks", hs_low_cnt, 3 * 96 * DIV);
        cmp_int("frame_tick_count", ft_got_cnt, ft_exp_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 VGA raster timing from the system clock: active-low hsync/vsync, display-enable, and the current pixel coordinate (x, y) consumed by the pixel renderers (pong and others). It also emits a one-clock `frame_tick` at the start of vertical blanking, which drives the game-logic `enable` input so that object state updates exactly once per frame, outside the visible area. It sits directly upstream of the renderers and of the final RGB/sync output register.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines); V_TOTAL = sum = 525

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `display_on`  out  1  high while the presented position is in the active area
- `x`  out  10  pixel column; 0 outside the active area
- `y`  out  9  pixel row; 0 outside the active area
- `frame_tick`  out  1  one-clk pulse at the start of vertical blanking

## Operation
- Internal counters `hcnt` (10 b, 0..H_TOTAL-1) and `vcnt` (10 b, 0..V_TOTAL-1) hold the *next* position to present.
- Pixel strobe `pix_stb`: constantly 1 by default; see Configuration.
- On each clk with rst_n=1 and pix_stb=1:
  - Outputs are loaded from a decode of (hcnt, vcnt).
  - hcnt increments. When hcnt=H_TOTAL-1, hcnt wraps to 0 and vcnt increments. When vcnt=V_TOTAL-1 and hcnt wraps, vcnt wraps to 0.
- Decode of position (h, v):
  - display_on = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync = 0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vsync = 0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
  - x = display_on ? h : 0; y = display_on ? v[8:0] : 0
  - frame_tick = 1 iff (h, v) = (0, V_ACTIVE)
- frame_tick is a single-clk pulse in all modes. It is cleared on the next clk edge regardless of pix_stb.
- On clks with pix_stb=0, outputs other than frame_tick hold their values.
- Reset, synchronous, overrides everything, including when asserted mid-frame:
  - hcnt=0, vcnt=0
  - hsync=1, vsync=1, display_on=0, x=0, y=0, frame_tick=0
  - The pixel-strobe toggle (if compiled in) = 0

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: position P appears on the outputs one pix_stb edge after the counters hold P. The first pix_stb edge after rst_n rises presents (0,0) with display_on=1.
- Each position is presented for one pixel period: 1 clk by default, 2 clks with the divider compiled in.
- Frame period: 800×525 = 420000 pixel periods. Line period: 800 pixel periods.
- hsync, vsync, display_on, x and y are mutually aligned, so downstream renderers register pixel with a known 1-clk lag.

## Configuration
- `VGA_CLK_DIV2_EN`:
  - Defined: a toggle register (reset 0) flips every clk, and pix_stb = toggle. The counters advance on every second clk, so a 50 MHz clk yields a 25 MHz pixel rate. The first output load happens on the 2nd clk after reset release.
  - Undefined: pix_stb ≡ 1 and clk is the pixel clock; there is no toggle register.

## Test plan
- Reset: hold rst_n=0 for 5 clks -> hsync=1, vsync=1, display_on=0, x=0, y=0, frame_tick=0. On the first strobe after release -> x=0, y=0, display_on=1.
- Line timing: count over line 0 -> display_on high for 640 consecutive pixel periods with x=0..639. hsync low for exactly 96 periods, starting at the period after x=639 plus 16.
- Frame timing: -> vsync low for exactly 2×800 pixel periods per frame. display_on high for 307200 pixel periods per frame. Last active position is x=639, y=479, followed by display_on=0, x=0, y=0.
- frame_tick: -> high for exactly 1 clk, once per 420000 clks (840000 with VGA_CLK_DIV2_EN). It coincides with the first presented position of line 480.
- Reset mid-frame: assert rst_n=0 for 1 clk at line 300, x=200 -> the outputs take reset values and the next strobe presents (0,0). No frame_tick until line 480 of the new frame.
- Divider build (VGA_CLK_DIV2_EN defined) -> x advances every 2 clks, and each x value is held for exactly 2 clks.
